// File: rtl/rv32im_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv32im_pkg
// Description : Shared definitions for the M-extension issue/retire stage:
//               funct3 encodings (MUL..REMU), issue FSM state encoding,
//               default datapath widths and a small decode helper.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32im_pkg;

  localparam int XLEN_DEF = 32;
  localparam int REGW_DEF = 5;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RETIRE = 2'd3
  } state_e;

  // The iterative unit only produces the low product word; the high-word
  // multiplies are retired as zero by the issue stage.
  function automatic logic is_unsupported(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_MULHU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rv32im_muldiv_special.sv
`default_nettype none
// ============================================================================
// Module      : rv32im_muldiv_special
// Description : Combinational detector for M-op cases whose result is known
//               without iterating: divide/remainder by zero, signed overflow
//               (MIN / -1) and multiply by zero. Used only when the
//               MULDIV_FASTPATH_EN build macro is defined.
// Revision    : 1.0 - initial release
// Ports       : funct3_i  - M-op selector
//               rs1_i     - operand 1
//               rs2_i     - operand 2
//               hit_o     - operands form a special case
//               value_o   - architectural result when hit_o is set
// ============================================================================
module rv32im_muldiv_special
  import rv32im_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic            hit_o,
  output logic [XLEN-1:0] value_o
);

  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  logic div_zero;
  logic sgn_ovf;

  assign div_zero = (rs2_i == '0);
  assign sgn_ovf  = (rs1_i == XMIN) && (rs2_i == '1);

  always_comb begin
    hit_o   = 1'b0;
    value_o = '0;
    case (funct3_i)
      F3_MUL: begin
        if ((rs1_i == '0) || (rs2_i == '0)) begin
          hit_o   = 1'b1;
          value_o = '0;
        end
      end
      F3_DIV: begin
        if (div_zero) begin
          hit_o   = 1'b1;
          value_o = '1;
        end else if (sgn_ovf) begin
          hit_o   = 1'b1;
          value_o = XMIN;
        end
      end
      F3_DIVU: begin
        if (div_zero) begin
          hit_o   = 1'b1;
          value_o = '1;
        end
      end
      F3_REM: begin
        if (div_zero) begin
          hit_o   = 1'b1;
          value_o = rs1_i;
        end else if (sgn_ovf) begin
          hit_o   = 1'b1;
          value_o = '0;
        end
      end
      F3_REMU: begin
        if (div_zero) begin
          hit_o   = 1'b1;
          value_o = rs1_i;
        end
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/rv32im_muldiv_issue.sv
`default_nettype none
// ============================================================================
// Module      : rv32im_muldiv_issue
// Description : Issue/retire stage in front of the iterative M-extension
//               unit. Accepts one decoded M-op, launches it into the unit,
//               collects the result and presents {rd, data} to writeback.
//               Handles flush, stall on writeback and unsupported high-word
//               multiplies. Build macro MULDIV_FASTPATH_EN resolves the
//               RISC-V special cases locally without launching the unit.
// Revision    : 1.0 - initial release
// Ports       : clk_i, reset_ni (async, active-low), flush_i
//               issue_*   - execute-side request (valid/ready, funct3, rd, rs1/rs2)
//               md_*_o    - to unit: clear, launch pulse, op, operands, ack
//               md_*_i    - from unit: busy, result-ready level, result
//               wb_*      - writeback valid/ready, rd, data
//               unsupported_o - pulse when MULH/MULHSU/MULHU retires as 0
// ============================================================================
module rv32im_muldiv_issue
  import rv32im_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int REGW = REGW_DEF
) (
  input  logic            clk_i,
  input  logic            reset_ni,
  input  logic            flush_i,
  input  logic            issue_valid_i,
  output logic            issue_ready_o,
  input  logic [2:0]      funct3_i,
  input  logic [REGW-1:0] rd_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  output logic            md_clear_o,
  output logic            md_data_ready_o,
  output logic [2:0]      md_operation_o,
  output logic [XLEN-1:0] md_operand1_o,
  output logic [XLEN-1:0] md_operand2_o,
  input  logic            md_busy_i,
  input  logic            md_data_ready_i,
  input  logic [XLEN-1:0] md_result_i,
  output logic            md_writeback_ce_o,
  output logic            wb_valid_o,
  input  logic            wb_ready_i,
  output logic [REGW-1:0] wb_rd_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic            unsupported_o
);

  state_e            state_q, state_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [REGW-1:0]   rd_q, rd_d;
  logic [XLEN-1:0]   op1_q, op1_d;
  logic [XLEN-1:0]   op2_q, op2_d;
  logic [XLEN-1:0]   data_q, data_d;
  logic              unsup_q, unsup_d;
  logic              clear_q, clear_d;
  logic              init_q;
  logic              wb_ce;
  logic              fast_hit;
  logic [XLEN-1:0]   fast_value;

`ifdef MULDIV_FASTPATH_EN
  rv32im_muldiv_special #(
    .XLEN(XLEN)
  ) u_special (
    .funct3_i (funct3_i),
    .rs1_i    (rs1_data_i),
    .rs2_i    (rs2_data_i),
    .hit_o    (fast_hit),
    .value_o  (fast_value)
  );
`else
  assign fast_hit   = 1'b0;
  assign fast_value = '0;
`endif

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= ST_IDLE;
      funct3_q <= '0;
      rd_q     <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      data_q   <= '0;
      unsup_q  <= 1'b0;
      clear_q  <= 1'b0;
      init_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      funct3_q <= funct3_d;
      rd_q     <= rd_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      data_q   <= data_d;
      unsup_q  <= unsup_d;
      clear_q  <= clear_d;
      init_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    funct3_d = funct3_q;
    rd_d     = rd_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    data_d   = data_q;
    unsup_d  = 1'b0;
    clear_d  = 1'b0;
    wb_ce    = 1'b0;

    if (flush_i) begin
      // Flush beats any concurrent issue or writeback handshake; the unit
      // only needs clearing if an op was actually handed to it.
      state_d = ST_IDLE;
      clear_d = (state_q == ST_LAUNCH) || (state_q == ST_WAIT);
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (issue_valid_i) begin
            funct3_d = funct3_i;
            rd_d     = rd_i;
            op1_d    = rs1_data_i;
            op2_d    = rs2_data_i;
            if (is_unsupported(funct3_i)) begin
              data_d  = '0;
              unsup_d = 1'b1;
              state_d = ST_RETIRE;
            end else if (fast_hit) begin
              data_d  = fast_value;
              state_d = ST_RETIRE;
            end else begin
              state_d = ST_LAUNCH;
            end
          end
        end
        ST_LAUNCH: begin
          state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (md_data_ready_i && !md_busy_i) begin
            data_d  = md_result_i;
            wb_ce   = 1'b1;
            state_d = ST_RETIRE;
          end
        end
        ST_RETIRE: begin
          if (wb_ready_i) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign issue_ready_o     = (state_q == ST_IDLE);
  assign md_data_ready_o   = (state_q == ST_LAUNCH);
  assign md_operation_o    = funct3_q;
  assign md_operand1_o     = op1_q;
  assign md_operand2_o     = op2_q;
  assign md_writeback_ce_o = wb_ce;
  assign wb_valid_o        = (state_q == ST_RETIRE);
  assign wb_rd_o           = rd_q;
  assign wb_data_o         = data_q;
  assign unsupported_o     = unsup_q;
  // Post-reset clear: low while reset is held, high from release until the
  // first rising edge so the unit samples exactly one clear.
  assign md_clear_o        = clear_q | (reset_ni & ~init_q);

endmodule
`default_nettype wire

// File: tb/tb_rv32im_muldiv_issue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_rv32im_muldiv_issue
// Description : Directed bench with a behavioural iterative-unit responder
//               and a writeback scoreboard for rv32im_muldiv_issue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32im_muldiv_issue;
  import rv32im_pkg::*;

  localparam int UNIT_LAT = 6;

  logic        clk_i = 1'b0;
  logic        reset_ni = 1'b0;
  logic        flush_i = 1'b0;
  logic        issue_valid_i = 1'b0;
  logic        issue_ready_o;
  logic [2:0]  funct3_i = '0;
  logic [4:0]  rd_i = '0;
  logic [31:0] rs1_data_i = '0;
  logic [31:0] rs2_data_i = '0;
  logic        md_clear_o;
  logic        md_data_ready_o;
  logic [2:0]  md_operation_o;
  logic [31:0] md_operand1_o;
  logic [31:0] md_operand2_o;
  logic        md_busy_i = 1'b0;
  logic        md_data_ready_i = 1'b0;
  logic [31:0] md_result_i = '0;
  logic        md_writeback_ce_o;
  logic        wb_valid_o;
  logic        wb_ready_i = 1'b1;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        unsupported_o;

  rv32im_muldiv_issue #(.XLEN(32), .REGW(5)) dut (
    .clk_i             (clk_i),
    .reset_ni          (reset_ni),
    .flush_i           (flush_i),
    .issue_valid_i     (issue_valid_i),
    .issue_ready_o     (issue_ready_o),
    .funct3_i          (funct3_i),
    .rd_i              (rd_i),
    .rs1_data_i        (rs1_data_i),
    .rs2_data_i        (rs2_data_i),
    .md_clear_o        (md_clear_o),
    .md_data_ready_o   (md_data_ready_o),
    .md_operation_o    (md_operation_o),
    .md_operand1_o     (md_operand1_o),
    .md_operand2_o     (md_operand2_o),
    .md_busy_i         (md_busy_i),
    .md_data_ready_i   (md_data_ready_i),
    .md_result_i       (md_result_i),
    .md_writeback_ce_o (md_writeback_ce_o),
    .wb_valid_o        (wb_valid_o),
    .wb_ready_i        (wb_ready_i),
    .wb_rd_o           (wb_rd_o),
    .wb_data_o         (wb_data_o),
    .unsupported_o     (unsupported_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;
  int n_launch = 0;
  int n_ce = 0;

  logic [4:0]  exp_rd_q[$];
  logic [31:0] exp_data_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference behaviour of the iterative unit (RISC-V M semantics, low word).
  function automatic logic [31:0] unit_calc(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    case (op)
      F3_MUL:  return a * b;
      F3_DIV:  begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        else return 32'($signed(a) / $signed(b));
      end
      F3_DIVU: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      F3_REM:  begin
        if (b == 32'd0) return a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        else return 32'($signed(a) % $signed(b));
      end
      F3_REMU: return (b == 32'd0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  // Unit responder: samples DUT requests mid-cycle, updates after the edge.
  logic        s_launch, s_clear, s_ce;
  logic [2:0]  s_op;
  logic [31:0] s_a, s_b, m_res;
  int          m_cnt;
  initial begin
    m_cnt = 0;
    m_res = '0;
    forever begin
      @(negedge clk_i);
      s_launch = md_data_ready_o;
      s_clear  = md_clear_o;
      s_ce     = md_writeback_ce_o;
      s_op     = md_operation_o;
      s_a      = md_operand1_o;
      s_b      = md_operand2_o;
      if (s_launch) n_launch++;
      if (s_ce) n_ce++;
      @(posedge clk_i);
      #1;
      if (!reset_ni || s_clear) begin
        md_busy_i = 1'b0;
        md_data_ready_i = 1'b0;
        m_cnt = 0;
      end else if (s_launch) begin
        md_busy_i = 1'b1;
        md_data_ready_i = 1'b0;
        m_cnt = UNIT_LAT;
        m_res = unit_calc(s_op, s_a, s_b);
      end else if (md_busy_i) begin
        m_cnt--;
        if (m_cnt == 0) begin
          md_busy_i = 1'b0;
          md_data_ready_i = 1'b1;
        end
      end else if (md_data_ready_i && s_ce) begin
        md_data_ready_i = 1'b0;
      end
      md_result_i = md_data_ready_i ? m_res : 32'd0;
    end
  end

  // Writeback monitor: every completed handshake must match the scoreboard.
  initial begin
    forever begin
      @(negedge clk_i);
      if (reset_ni && !flush_i && wb_valid_o && wb_ready_i) begin
        if (exp_data_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_wb: got rd=%0d data=%h, expected no writeback", wb_rd_o, wb_data_o);
        end else begin
          chk("wb_rd", 32'(wb_rd_o), 32'(exp_rd_q.pop_front()));
          chk("wb_data", wb_data_o, exp_data_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Presents one op and returns #1 after the accepting edge.
  task automatic issue(input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input bit push);
    int t = 0;
    while (!issue_ready_o && t < 200) begin
      tick();
      t++;
    end
    if (!issue_ready_o) begin
      n_vec++;
      n_err++;
      $display("FAIL issue_timeout: got issue_ready_o=0, expected 1 within 200 cycles");
    end
    issue_valid_i = 1'b1;
    funct3_i = f3;
    rd_i = rd;
    rs1_data_i = a;
    rs2_data_i = b;
    if (push) begin
      exp_rd_q.push_back(rd);
      exp_data_q.push_back(exp);
    end
    tick();
    issue_valid_i = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_data_q.size() != 0 || !issue_ready_o) && t < 200) begin
      tick();
      t++;
    end
    if (exp_data_q.size() != 0 || !issue_ready_o) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending writebacks, expected 0", exp_data_q.size());
      exp_rd_q.delete();
      exp_data_q.delete();
    end
  endtask

  logic [2:0]  fv_op[8]  = '{F3_DIV, F3_DIVU, F3_REM, F3_REMU, F3_DIV, F3_REM, F3_MUL, F3_MUL};
  logic [31:0] fv_a[8]   = '{32'd5, 32'd9, 32'd9, 32'hABCD, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd55};
  logic [31:0] fv_b[8]   = '{32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1234, 32'd0};
  logic [31:0] fv_exp[8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd9, 32'hABCD, 32'h8000_0000, 32'd0, 32'd0, 32'd0};

  logic [2:0]  nv_op[6]  = '{F3_DIV, F3_REM, F3_MUL, F3_DIVU, F3_REMU, F3_MUL};
  logic [31:0] nv_a[6]   = '{32'hFFFF_FFEC, 32'hFFFF_FFEC, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd100, 32'd2};
  logic [31:0] nv_b[6]   = '{32'd3, 32'd3, 32'hFFFF_FFFF, 32'd2, 32'd7, 32'd3};
  logic [31:0] nv_exp[6] = '{32'hFFFF_FFFA, 32'hFFFF_FFFE, 32'd1, 32'h7FFF_FFFF, 32'd2, 32'd6};
  logic [4:0]  nv_rd[6]  = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0};

  int l0, c0, t;

  initial begin
    // Reset values while reset is held.
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_issue_ready", 32'(issue_ready_o), 32'd1);
    chk("rst_wb_valid", 32'(wb_valid_o), 32'd0);
    chk("rst_md_clear", 32'(md_clear_o), 32'd0);
    chk("rst_md_launch", 32'(md_data_ready_o), 32'd0);
    chk("rst_unsupported", 32'(unsupported_o), 32'd0);
    @(negedge clk_i);
    reset_ni = 1'b1;
    #1;
    chk("clear_after_release", 32'(md_clear_o), 32'd1);
    tick();
    chk("clear_one_cycle", 32'(md_clear_o), 32'd0);

    // DIVU 100/7 through the unit.
    l0 = n_launch;
    c0 = n_ce;
    issue(F3_DIVU, 5'd5, 32'd100, 32'd7, 32'd14, 1'b1);
    chk("launch_pulse", 32'(md_data_ready_o), 32'd1);
    chk("launch_op", 32'(md_operation_o), 32'(F3_DIVU));
    chk("launch_op1", md_operand1_o, 32'd100);
    chk("launch_op2", md_operand2_o, 32'd7);
    chk("launch_busy_ready", 32'(issue_ready_o), 32'd0);
    tick();
    chk("launch_single", 32'(md_data_ready_o), 32'd0);
    chk("op1_held", md_operand1_o, 32'd100);
    drain();
    chk("divu_launch_count", 32'(n_launch - l0), 32'd1);
    chk("divu_ce_count", 32'(n_ce - c0), 32'd1);

    // REM -7 % 2 with writeback stalled for 4 cycles.
    wb_ready_i = 1'b0;
    issue(F3_REM, 5'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b1);
    t = 0;
    while (!wb_valid_o && t < 100) begin
      tick();
      t++;
    end
    for (int i = 0; i < 4; i++) begin
      chk("stall_wb_valid", 32'(wb_valid_o), 32'd1);
      chk("stall_wb_data", wb_data_o, 32'hFFFF_FFFF);
      chk("stall_wb_rd", 32'(wb_rd_o), 32'd3);
      chk("stall_issue_ready", 32'(issue_ready_o), 32'd0);
      tick();
    end
    wb_ready_i = 1'b1;
    drain();

    // MULHU: short path, no launch.
    l0 = n_launch;
    issue(F3_MULHU, 5'd7, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 1'b1);
    chk("mulhu_unsup_pulse", 32'(unsupported_o), 32'd1);
    chk("mulhu_wb_valid", 32'(wb_valid_o), 32'd1);
    chk("mulhu_wb_data", wb_data_o, 32'd0);
    tick();
    chk("mulhu_unsup_drop", 32'(unsupported_o), 32'd0);
    issue(F3_MULH, 5'd8, 32'hFFFF_FFFF, 32'd5, 32'd0, 1'b1);
    issue(F3_MULHSU, 5'd9, 32'd77, 32'd88, 32'd0, 1'b1);
    drain();
    chk("mulh_no_launch", 32'(n_launch - l0), 32'd0);

    // Special cases: short path with fast-path build, unit otherwise.
    l0 = n_launch;
    for (int i = 0; i < 8; i++) begin
      issue(fv_op[i], 5'(i + 16), fv_a[i], fv_b[i], fv_exp[i], 1'b1);
      if (i == 0) begin
`ifdef MULDIV_FASTPATH_EN
        chk("fast_div0_wb_valid", 32'(wb_valid_o), 32'd1);
        chk("fast_div0_no_launch", 32'(md_data_ready_o), 32'd0);
`else
        chk("div0_launched", 32'(md_data_ready_o), 32'd1);
`endif
      end
      drain();
    end
`ifdef MULDIV_FASTPATH_EN
    chk("fast_launch_count", 32'(n_launch - l0), 32'd0);
`else
    chk("special_launch_count", 32'(n_launch - l0), 32'd8);
`endif

    // Regular ops, including rd=0.
    for (int i = 0; i < 6; i++) begin
      issue(nv_op[i], nv_rd[i], nv_a[i], nv_b[i], nv_exp[i], 1'b1);
    end
    drain();

    // Flush three cycles into WAIT.
    issue(F3_DIV, 5'd9, 32'd1000, 32'd10, 32'd0, 1'b0);
    tick();
    tick();
    tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("flush_clear", 32'(md_clear_o), 32'd1);
    chk("flush_wb_valid", 32'(wb_valid_o), 32'd0);
    chk("flush_issue_ready", 32'(issue_ready_o), 32'd1);
    tick();
    chk("flush_clear_drop", 32'(md_clear_o), 32'd0);
    issue(F3_MUL, 5'd4, 32'd6, 32'd7, 32'd42, 1'b1);
    drain();

    // Asynchronous reset during WAIT.
    issue(F3_DIVU, 5'd6, 32'd50, 32'd5, 32'd0, 1'b0);
    tick();
    tick();
    reset_ni = 1'b0;
    #1;
    chk("arst_issue_ready", 32'(issue_ready_o), 32'd1);
    chk("arst_wb_valid", 32'(wb_valid_o), 32'd0);
    chk("arst_launch", 32'(md_data_ready_o), 32'd0);
    chk("arst_clear", 32'(md_clear_o), 32'd0);
    chk("arst_wb_data", wb_data_o, 32'd0);
    chk("arst_operand1", md_operand1_o, 32'd0);
    @(posedge clk_i);
    @(negedge clk_i);
    reset_ni = 1'b1;
    #1;
    chk("arst_release_clear", 32'(md_clear_o), 32'd1);
    tick();
    chk("arst_clear_drop", 32'(md_clear_o), 32'd0);
    issue(F3_MUL, 5'd8, 32'd3, 32'hFFFF_FFFE, 32'hFFFF_FFFA, 1'b1);
    drain();

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got simulation still running, expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
